// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - keyboard command encodings, set-2 scan codes and repeat FSM states
package kbd_pkg;

    typedef enum logic [2:0] {
        CMD_NONE    = 3'd0,
        CMD_UP      = 3'd1,
        CMD_DOWN    = 3'd2,
        CMD_LEFT    = 3'd3,
        CMD_RIGHT   = 3'd4,
        CMD_REVEAL  = 3'd5,
        CMD_FLAG    = 3'd6,
        CMD_NEWGAME = 3'd7
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_t;

    localparam logic [7:0] SC_ARROW_UP    = 8'h75;
    localparam logic [7:0] SC_W           = 8'h1D;
    localparam logic [7:0] SC_ARROW_DOWN  = 8'h72;
    localparam logic [7:0] SC_S           = 8'h1B;
    localparam logic [7:0] SC_ARROW_LEFT  = 8'h6B;
    localparam logic [7:0] SC_A           = 8'h1C;
    localparam logic [7:0] SC_ARROW_RIGHT = 8'h74;
    localparam logic [7:0] SC_D           = 8'h23;
    localparam logic [7:0] SC_ENTER       = 8'h5A;
    localparam logic [7:0] SC_SPACE       = 8'h29;
    localparam logic [7:0] SC_F           = 8'h2B;
    localparam logic [7:0] SC_N           = 8'h31;

    function automatic cmd_t decode_key(input logic [7:0] code);
        case (code)
            SC_ARROW_UP, SC_W:       decode_key = CMD_UP;
            SC_ARROW_DOWN, SC_S:     decode_key = CMD_DOWN;
            SC_ARROW_LEFT, SC_A:     decode_key = CMD_LEFT;
            SC_ARROW_RIGHT, SC_D:    decode_key = CMD_RIGHT;
            SC_ENTER, SC_SPACE:      decode_key = CMD_REVEAL;
            SC_F:                    decode_key = CMD_FLAG;
            SC_N:                    decode_key = CMD_NEWGAME;
            default:                 decode_key = CMD_NONE;
        endcase
    endfunction

    // Only cursor movement auto-repeats; reveal/flag/new-game fire once per press.
    function automatic logic is_direction(input cmd_t c);
        return (c == CMD_UP) || (c == CMD_DOWN) || (c == CMD_LEFT) || (c == CMD_RIGHT);
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - small command queue with wrap-bit pointers and same-cycle pop-through on full
module cmd_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_drop,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    input  logic             rd_ready
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_pop   = rd_ready && !empty;
    // A pop in the same cycle frees the slot, so a push into a full queue still lands.
    assign do_push  = wr_valid && (!full || do_pop);
    assign wr_drop  = wr_valid && !do_push;
    assign rd_valid = !empty;
    assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/key_cmd_scheduler.sv
// rtl/key_cmd_scheduler.sv - scan-code decode, direction auto-repeat and command queueing
module key_cmd_scheduler
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       key_valid,
    input  logic       key_make,
    input  logic [7:0] key_code,
    output logic       cmd_valid,
    output logic [2:0] cmd,
    input  logic       cmd_ready,
    output logic       overflow,
    input  logic       clr_overflow
);
    localparam logic [31:0] DELAY_LOAD = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] RATE_LOAD  = 32'(REPEAT_RATE - 1);

    cmd_t        key_cmd;
    logic        key_push;
    logic        dir_make;
    logic        rep_push;
    logic        push_valid;
    logic [2:0]  push_data;
    logic        push_drop;

    rep_state_t  state, state_nx;
    logic [7:0]  held_code, held_code_nx;
    cmd_t        held_cmd, held_cmd_nx;
    logic [31:0] counter, counter_nx;

    always_comb begin
        key_cmd  = decode_key(key_code);
        key_push = key_valid && key_make && (key_cmd != CMD_NONE);
        dir_make = key_push && is_direction(key_cmd);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            held_code <= '0;
            held_cmd  <= CMD_NONE;
            counter   <= '0;
        end else begin
            state     <= state_nx;
            held_code <= held_code_nx;
            held_cmd  <= held_cmd_nx;
            counter   <= counter_nx;
        end
    end

    // A release only cancels the repeat if it is the key currently being held.
    always_comb begin
        state_nx     = state;
        held_code_nx = held_code;
        held_cmd_nx  = held_cmd;
        counter_nx   = counter;
        rep_push     = 1'b0;
        if (dir_make) begin
            state_nx     = ST_DELAY;
            held_code_nx = key_code;
            held_cmd_nx  = key_cmd;
            counter_nx   = DELAY_LOAD;
        end else if (state != ST_IDLE) begin
            if (key_valid && !key_make && (key_code == held_code)) begin
                state_nx = ST_IDLE;
            end else if (counter == 32'd0) begin
                rep_push   = 1'b1;
                state_nx   = ST_REPEAT;
                counter_nx = RATE_LOAD;
            end else begin
                counter_nx = counter - 32'd1;
            end
        end
    end

    // The live key event owns the single write port; a coincident repeat is lost.
    assign push_valid = key_push || rep_push;
    assign push_data  = key_push ? key_cmd : held_cmd;

    cmd_fifo #(
        .WIDTH(3),
        .DEPTH(FIFO_DEPTH)
    ) u_cmd_fifo (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .wr_valid (push_valid),
        .wr_data  (push_data),
        .wr_drop  (push_drop),
        .rd_valid (cmd_valid),
        .rd_data  (cmd),
        .rd_ready (cmd_ready)
    );

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)             overflow <= 1'b0;
        else if (push_drop)    overflow <= 1'b1;
        else if (clr_overflow) overflow <= 1'b0;
    end

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// tb/tb_key_cmd_scheduler.sv - scoreboard bench for key_cmd_scheduler
module tb_key_cmd_scheduler;
    import kbd_pkg::*;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       key_valid;
    logic       key_make;
    logic [7:0] key_code;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       cmd_ready;
    logic       overflow;
    logic       clr_overflow;

    typedef struct {
        logic [2:0] c;
        int         cy;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    key_cmd_scheduler #(
        .FIFO_DEPTH   (4),
        .REPEAT_DELAY (8),
        .REPEAT_RATE  (4)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .key_valid    (key_valid),
        .key_make     (key_make),
        .key_code     (key_code),
        .cmd_valid    (cmd_valid),
        .cmd          (cmd),
        .cmd_ready    (cmd_ready),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc++;

    // Every handshake must match the head of the scoreboard in value and cycle.
    always @(negedge CLOCK_50) begin
        if (!reset && cmd_valid && cmd_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL pop_unexpected: got cmd=%0d at cycle %0d, expected no output", cmd, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (cmd !== mon_e.c || cyc != mon_e.cy)
                    $display("FAIL pop_order: got cmd=%0d at cycle %0d, expected cmd=%0d at cycle %0d",
                             cmd, cyc, mon_e.c, mon_e.cy);
                else
                    n_pass++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic key_event(input logic mk, input logic [7:0] code);
        key_valid = 1'b1;
        key_make  = mk;
        key_code  = code;
        step(1);
        key_valid = 1'b0;
        key_make  = 1'b0;
        key_code  = 8'h00;
    endtask

    task automatic expect_cmd(input logic [2:0] c, input int cy);
        exp_t e;
        e.c  = c;
        e.cy = cy;
        sb.push_back(e);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step(2);
        n_checks++; if (cmd_valid !== 1'b0) $display("FAIL reset_cmd_valid: got %b, expected 0", cmd_valid); else n_pass++;
        n_checks++; if (cmd !== 3'd0) $display("FAIL reset_cmd: got %0d, expected 0", cmd); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b, expected 0", overflow); else n_pass++;
        n_checks++; if (dut.state !== ST_IDLE) $display("FAIL reset_state: got %0d, expected IDLE", dut.state); else n_pass++;
        n_checks++; if (dut.counter !== 32'd0) $display("FAIL reset_counter: got %0d, expected 0", dut.counter); else n_pass++;
        n_checks++; if (dut.held_code !== 8'h00) $display("FAIL reset_held_code: got %h, expected 00", dut.held_code); else n_pass++;
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_single;
        int t;
        cmd_ready = 1'b1;
        t = cyc;
        expect_cmd(CMD_UP, t + 1);
        key_event(1'b1, 8'h1D);
        step(2);
        n_checks++; if (cmd_valid !== 1'b0) $display("FAIL single_one_cycle: cmd_valid=%b, expected 0", cmd_valid); else n_pass++;
        key_event(1'b0, 8'h1D);
        step(12);
        n_checks++; if (sb.size() != 0) $display("FAIL single_drain: %0d outstanding, expected 0", sb.size()); else n_pass++;
        n_checks++; if (dut.state !== ST_IDLE) $display("FAIL single_state: got %0d, expected IDLE", dut.state); else n_pass++;
    endtask

    task automatic test_decode;
        logic [7:0] codes [14];
        logic [2:0] cmds  [14];
        int t;
        codes = '{8'h75, 8'h1D, 8'h72, 8'h1B, 8'h6B, 8'h1C, 8'h74, 8'h23, 8'h5A, 8'h29, 8'h2B, 8'h31, 8'h45, 8'h00};
        cmds  = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7, 3'd0, 3'd0};
        cmd_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            t = cyc;
            if (cmds[i] != 3'd0) expect_cmd(cmds[i], t + 1);
            key_event(1'b1, codes[i]);
            key_event(1'b0, codes[i]);
            step(1);
        end
        step(4);
        n_checks++; if (sb.size() != 0) $display("FAIL decode_drain: %0d outstanding, expected 0", sb.size()); else n_pass++;
    endtask

    task automatic test_repeat;
        int t;
        cmd_ready = 1'b1;
        t = cyc;
        expect_cmd(CMD_LEFT, t + 1);
        expect_cmd(CMD_LEFT, t + 9);
        expect_cmd(CMD_LEFT, t + 13);
        expect_cmd(CMD_LEFT, t + 17);
        key_event(1'b1, 8'h6B);
        while (cyc < t + 20) step(1);
        key_event(1'b0, 8'h6B);
        step(12);
        n_checks++; if (sb.size() != 0) $display("FAIL repeat_drain: %0d outstanding, expected 0", sb.size()); else n_pass++;
        n_checks++; if (dut.state !== ST_IDLE) $display("FAIL repeat_state: got %0d, expected IDLE", dut.state); else n_pass++;
    endtask

    task automatic test_overflow;
        int m;
        cmd_ready = 1'b0;
        repeat (6) key_event(1'b1, 8'h29);
        step(1);
        n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b, expected 1", overflow); else n_pass++;
        n_checks++; if (cmd_valid !== 1'b1 || cmd !== 3'd5) $display("FAIL ovf_head: valid=%b cmd=%0d, expected 1/5", cmd_valid, cmd); else n_pass++;
        m = cyc;
        for (int i = 0; i < 4; i++) expect_cmd(CMD_REVEAL, m + i);
        cmd_ready = 1'b1;
        step(4);
        n_checks++; if (cmd_valid !== 1'b0 || cmd !== 3'd0) $display("FAIL ovf_empty: valid=%b cmd=%0d, expected 0/0", cmd_valid, cmd); else n_pass++;
        n_checks++; if (sb.size() != 0) $display("FAIL ovf_drain: %0d outstanding, expected 0", sb.size()); else n_pass++;
        n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b, expected 1", overflow); else n_pass++;
        clr_overflow = 1'b1;
        step(1);
        clr_overflow = 1'b0;
        n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b, expected 0", overflow); else n_pass++;
        cmd_ready = 1'b0;
        repeat (4) key_event(1'b1, 8'h2B);
        clr_overflow = 1'b1;
        key_event(1'b1, 8'h2B);
        clr_overflow = 1'b0;
        n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_drop_wins: got %b, expected 1", overflow); else n_pass++;
        clr_overflow = 1'b1;
        step(1);
        clr_overflow = 1'b0;
        m = cyc;
        for (int i = 0; i < 4; i++) expect_cmd(CMD_FLAG, m + i);
        cmd_ready = 1'b1;
        step(6);
        n_checks++; if (sb.size() != 0) $display("FAIL ovf_drain2: %0d outstanding, expected 0", sb.size()); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_clear2: got %b, expected 0", overflow); else n_pass++;
    endtask

    task automatic test_full_pop;
        int m;
        cmd_ready = 1'b0;
        key_event(1'b1, 8'h5A);
        key_event(1'b1, 8'h2B);
        key_event(1'b1, 8'h31);
        key_event(1'b1, 8'h5A);
        m = cyc;
        expect_cmd(CMD_REVEAL, m);
        expect_cmd(CMD_FLAG, m + 1);
        expect_cmd(CMD_NEWGAME, m + 2);
        expect_cmd(CMD_REVEAL, m + 3);
        expect_cmd(CMD_FLAG, m + 4);
        cmd_ready = 1'b1;
        key_event(1'b1, 8'h2B);
        step(6);
        n_checks++; if (sb.size() != 0) $display("FAIL fullpop_drain: %0d outstanding, expected 0", sb.size()); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL fullpop_overflow: got %b, expected 0", overflow); else n_pass++;
    endtask

    task automatic test_collision;
        int t;
        cmd_ready = 1'b1;
        t = cyc;
        expect_cmd(CMD_UP, t + 1);
        expect_cmd(CMD_UP, t + 9);
        expect_cmd(CMD_NEWGAME, t + 13);
        expect_cmd(CMD_UP, t + 17);
        key_event(1'b1, 8'h75);
        while (cyc < t + 12) step(1);
        key_event(1'b1, 8'h31);
        n_checks++; if (dut.state !== ST_REPEAT) $display("FAIL collide_state: got %0d, expected REPEAT", dut.state); else n_pass++;
        n_checks++; if (dut.counter !== 32'd3) $display("FAIL collide_reload: got %0d, expected 3", dut.counter); else n_pass++;
        while (cyc < t + 20) step(1);
        key_event(1'b0, 8'h75);
        step(10);
        n_checks++; if (sb.size() != 0) $display("FAIL collide_drain: %0d outstanding, expected 0", sb.size()); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int t;
        cmd_ready = 1'b0;
        t = cyc;
        key_event(1'b1, 8'h1D);
        key_event(1'b1, 8'h5A);
        while (cyc < t + 10) step(1);
        n_checks++; if (dut.state !== ST_REPEAT || cmd_valid !== 1'b1) $display("FAIL rmid_setup: state=%0d valid=%b, expected REPEAT/1", dut.state, cmd_valid); else n_pass++;
        @(negedge CLOCK_50);
        reset = 1'b1;
        #1;
        n_checks++; if (cmd_valid !== 1'b0 || cmd !== 3'd0) $display("FAIL rmid_flush: valid=%b cmd=%0d, expected 0/0", cmd_valid, cmd); else n_pass++;
        n_checks++; if (dut.state !== ST_IDLE) $display("FAIL rmid_state: got %0d, expected IDLE", dut.state); else n_pass++;
        cmd_ready = 1'b1;
        key_event(1'b1, 8'h2B);
        step(1);
        reset = 1'b0;
        step(15);
        n_checks++; if (cmd_valid !== 1'b0) $display("FAIL rmid_quiet: cmd_valid=%b, expected 0", cmd_valid); else n_pass++;
        t = cyc;
        expect_cmd(CMD_LEFT, t + 1);
        key_event(1'b1, 8'h6B);
        key_event(1'b0, 8'h6B);
        step(4);
        n_checks++; if (sb.size() != 0) $display("FAIL rmid_drain: %0d outstanding, expected 0", sb.size()); else n_pass++;
    endtask

    initial begin
        reset        = 1'b1;
        key_valid    = 1'b0;
        key_make     = 1'b0;
        key_code     = 8'h00;
        cmd_ready    = 1'b0;
        clr_overflow = 1'b0;
        test_reset();
        test_single();
        test_decode();
        test_repeat();
        test_overflow();
        test_full_pop();
        test_collision();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
